// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
//   state_t        sequencer states (IDLE, ACCESS, DONE)
//   PORT_PIPE/LOAD requester port indices (MEM stage, loader)
//   DEF_ADDR_W/DATA_W default memory word-address and data widths
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_PIPE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 32;

    // Word-only memory: any nonzero byte offset is rejected.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_if: requester handshakes (two ports) plus the data-memory bus.
//   slave  modport: seen by the arbiter (requests in, completions/strobes out)
//   master modport: seen by the requesters/memory side
//   req*/we*/addr*/wdata*   per-port request (byte address)
//   ready*/err*/rdata*      per-port completion
//   busy                    arbiter not idle
//   readSig/writeSig/address/dataIn/dataOut  memory strobes, word address, data
interface dmem_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [31:0]       addr0;
    logic [31:0]       addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ready0;
    logic              ready1;
    logic              err0;
    logic              err1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic              readSig;
    logic              writeSig;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] dataIn;
    logic [DATA_W-1:0] dataOut;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dataOut,
        output ready0, ready1, err0, err1, rdata0, rdata1, busy,
               readSig, writeSig, address, dataIn
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dataOut,
        input  ready0, ready1, err0, err1, rdata0, rdata1, busy,
               readSig, writeSig, address, dataIn
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin select.
//   req0, req1  requests
//   lastGrant   port granted most recently
//   gnt_valid   at least one request present
//   gnt_idx     selected port; on a tie the port not granted last wins
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic lastGrant,
    output logic gnt_valid,
    output logic gnt_idx
);

    assign gnt_valid = req0 | req1;
    assign gnt_idx   = (req0 & req1) ? ~lastGrant : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the pipeline MEM stage
// (port 0) and the loader (port 1). One access at a time, round-robin on
// contention, fixed wait states, one-cycle ready/err completion pulses.
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  dmem_if.slave: request ports, completions, memory bus
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; grant and latch it
// ACCESS | strobe held for WAIT_CYCLES+1 cycles; last cycle captures read
// DONE   | ready (and err) pulse on the granted port; back to IDLE
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_gnt;
    logic [3:0]        r_cnt;
    logic              r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_data_in;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_read_sig;
    logic              r_write_sig;
    logic              r_ready0;
    logic              r_ready1;
    logic              r_err0;
    logic              r_err1;

    logic              w_gnt_valid;
    logic              w_gnt_idx;
    logic              w_req_we;
    logic [ADDR_W+1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_wdata;
    logic              w_misaligned;
    logic              w_grant;
    logic              w_access_done;
    logic              w_done_port;
    logic              w_done_err;

    rr_arb2 u_rr_arb2 (
        .req0      (bus.req0),
        .req1      (bus.req1),
        .lastGrant (r_last_gnt),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_req_we     = w_gnt_idx ? bus.we1 : bus.we0;
    assign w_req_addr   = w_gnt_idx ? bus.addr1[ADDR_W+1:0] : bus.addr0[ADDR_W+1:0];
    assign w_req_wdata  = w_gnt_idx ? bus.wdata1 : bus.wdata0;
    assign w_misaligned = is_misaligned(w_req_addr[1:0]);

    // A misaligned grant enters DONE straight from IDLE, before r_port is
    // latched, so the completion port comes from the arbiter in that case.
    assign w_done_port = (r_state == IDLE) ? w_gnt_idx : r_port;
    assign w_done_err  = (r_state == IDLE) ? w_misaligned : 1'b0;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        w_access_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = w_misaligned ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_access_done = 1'b1;
                    w_state_nxt   = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_last_gnt  <= 1'b1;
            r_cnt       <= 4'd0;
            r_port      <= PORT_PIPE;
            r_we        <= 1'b0;
            r_address   <= '0;
            r_data_in   <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_read_sig  <= 1'b0;
            r_write_sig <= 1'b0;
            r_ready0    <= 1'b0;
            r_ready1    <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready0 <= 1'b0;
            r_ready1 <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;

            if (w_grant) begin
                r_port     <= w_gnt_idx;
                r_we       <= w_req_we;
                r_last_gnt <= w_gnt_idx;
                r_cnt      <= CNT_LOAD;
                // Memory-side registers only move for a real access so the
                // bus holds its last value across rejected requests.
                if (!w_misaligned) begin
                    r_address   <= w_req_addr[ADDR_W+1:2];
                    r_data_in   <= w_req_wdata;
                    r_read_sig  <= ~w_req_we;
                    r_write_sig <= w_req_we;
                end
            end

            if (r_state == ACCESS) begin
                if (w_access_done) begin
                    r_read_sig  <= 1'b0;
                    r_write_sig <= 1'b0;
                    if (!r_we) begin
                        if (r_port == PORT_PIPE) r_rdata0 <= bus.dataOut;
                        else                     r_rdata1 <= bus.dataOut;
                    end
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end

            if (w_state_nxt == DONE) begin
                if (w_done_port == PORT_PIPE) begin
                    r_ready0 <= 1'b1;
                    r_err0   <= w_done_err;
                end else begin
                    r_ready1 <= 1'b1;
                    r_err1   <= w_done_err;
                end
            end
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.readSig  = r_read_sig;
    assign bus.writeSig = r_write_sig;
    assign bus.address  = r_address;
    assign bus.dataIn   = r_data_in;
    assign bus.ready0   = r_ready0;
    assign bus.ready1   = r_ready1;
    assign bus.err0     = r_err0;
    assign bus.err1     = r_err1;
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the data memory (`readSig`, `writeSig`, 18-bit word address, 32-bit data). It shares the memory between the pipeline MEM stage (port 0) and the program/debug loader (port 1). It grants one request at a time, round-robin on contention. It drives the memory strobes for a fixed number of wait states and returns read data with a one-cycle `ready` pulse.

## Interface
- `ADDR_W`, 18: memory word-address width.
- `DATA_W`, 32: data width.
- `WAIT_CYCLES`, 2: extra cycles a memory access is held beyond the first; legal range 0..15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request; held high until the matching `ready`.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  32  byte address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ready0` / `ready1`  out  1  one-cycle completion pulse.
- `err0` / `err1`  out  1  one-cycle pulse, coincident with `ready`, for a misaligned address.
- `rdata0` / `rdata1`  out  DATA_W  read result; valid while `ready` is high, held until the next completion on that port.
- `busy`  out  1  high in every state except IDLE.
- `readSig`  out  1  memory read strobe.
- `writeSig`  out  1  memory write strobe.
- `address`  out  ADDR_W  memory word address.
- `dataIn`  out  DATA_W  memory write data.
- `dataOut`  in  DATA_W  memory read data.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port not granted last. `lastGrant` resets to 1, so port 0 wins the first tie.
  - On grant: latch port index, `we`, `addr[ADDR_W+1:2]`, `wdata`; update `lastGrant`; load `cnt` = WAIT_CYCLES.
  - Misaligned address (`addr[1:0]` != 0): go straight to DONE with error set and no memory strobe.
  - Otherwise: go to ACCESS.
- **ACCESS**
  - Drive `readSig` = !we_l or `writeSig` = we_l, `address` = latched word address, `dataIn` = latched data.
  - Decrement `cnt`. When `cnt` = 0, capture `dataOut` into the granted port's `rdata` (reads only) and go to DONE.
- **DONE**
  - Pulse `ready` (and `err` if flagged) on the granted port only; strobes low; return to IDLE.
- Outside ACCESS, `readSig` and `writeSig` are 0 and `address`/`dataIn` hold their last value.
- A request still high in the IDLE cycle after `ready` is treated as a new transaction. Requesters drop `req` on the edge on which they see `ready`.
- Request inputs are ignored outside IDLE; a losing requester simply waits.
- Writes leave `rdata` unchanged.

## Timing
- Reset values: state IDLE, `lastGrant` 1, `cnt` 0. All outputs are 0: `ready*`, `err*`, `rdata*`, `busy`, `readSig`, `writeSig`, `address`, `dataIn`.
- Reset mid-ACCESS drops the strobes immediately (asynchronous). A partial write is acceptable; no `ready` is produced.
- Aligned access latency, with the request sampled in IDLE at edge 0:
  - ACCESS occupies WAIT_CYCLES+1 cycles.
  - `ready` is high in cycle WAIT_CYCLES+2; 4 cycles at the default.
- Misaligned access: `ready` and `err` high in cycle 1.
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles, including the IDLE cycle.
- Simultaneous requests alternate strictly, so neither port starves.

## Structure
- Package `dmem_pkg`:
  - state enum {IDLE, ACCESS, DONE};
  - port index constants `PORT_PIPE` = 0, `PORT_LOAD` = 1;
  - default `ADDR_W` and `DATA_W`.
- One sub-module, `rr_arb2`: combinational two-way round-robin select. Inputs: `req0`, `req1`, `lastGrant`. Outputs: `gnt_valid`, `gnt_idx`.
- The FSM, wait counter and output registers stay in `dmem_arbiter`.

## Test plan
- Port 0 write, addr 0x400, data 0x55555555, WAIT_CYCLES = 2 -> `writeSig` high for 3 cycles with `address` 0x100; `ready0` pulses in cycle 4. A following read of 0x400 returns 0x55555555 on `rdata0`.
- `req0` and `req1` both rise in the same cycle, reading 0x418 and 0x424 -> port 0 served first, then port 1. The next tie goes to port 0 again, because the tie-break alternates.
- Port 1 read of addr 0x00000026 (misaligned) -> `ready1` and `err1` high in cycle 1; `readSig` never asserted; `rdata1` unchanged.
- Assert `rst` low during the second ACCESS cycle of a write -> `writeSig` drops in the same cycle; all outputs 0; no `ready`. After release, a new request completes normally.
- `req0` held high continuously with `req1` idle -> consecutive transactions every 5 cycles; `busy` low only in each IDLE cycle.
- WAIT_CYCLES = 0 -> single-cycle ACCESS; `ready` in cycle 2.
